mdio_arbiter_master: RTL and testbench

MDIO_ARBITER_MASTER -- requirements
Module: mdio_arbiter_master

---
 rtl/mdio_arbiter_master.sv | 180 ++++++++++++++++++
 tb/tb_mdio_arbiter_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_arbiter_master.sv
// mdio_arbiter_master
//   Two-port round-robin arbiter in front of a Clause-22 MDIO master. Accepts one
//   request at a time, shifts a 64-bit-time management frame (32 preamble 1s, ST,
//   OP, PHYAD, REGAD, TA, 16 data bits) out on mdc_out/mdio_o, captures read data
//   from mdio_i, and reports completion with a one-cycle response pulse.
// Ports
//   clk_in, rst_in            : system clock, synchronous active-high reset
//   req_valid_in[1:0]         : per-port request valid (bit0 = port0)
//   req_write_in[1:0]         : per-port 1 = write, 0 = read
//   req_phy_in/req_reg_in     : PHYAD / REGAD, port0 in [4:0], port1 in [9:5]
//   req_wdata_in[31:0]        : write data, port0 [15:0], port1 [31:16]
//   req_ready_out[1:0]        : one-cycle accept pulse to the granted port
//   resp_valid_out            : one-cycle completion pulse
//   resp_port_out             : port owning the completed transaction
//   resp_rdata_out[15:0]      : read data (0 for writes), held until next response
//   resp_err_out              : read turnaround bit sampled high (no PHY response)
//   mdc_out, mdio_o, mdio_oe  : management clock and tristate-split data out
//   mdio_i                    : data in from the external pad buffer
//   busy_out                  : high from accept through resp_valid_out
//   state_dbg_out[1:0]        : current FSM state (0 idle, 1 shift, 2 done)
// Handshake: a port holds valid and its fields stable until it sees its ready bit;
// ready is only ever raised in IDLE and the transfer happens in that same cycle.
module mdio_arbiter_master #(
   parameter int MDC_HALF = 20
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [1:0]  req_valid_in,
   input  logic [1:0]  req_write_in,
   input  logic [9:0]  req_phy_in,
   input  logic [9:0]  req_reg_in,
   input  logic [31:0] req_wdata_in,
   output logic [1:0]  req_ready_out,
   output logic        resp_valid_out,
   output logic        resp_port_out,
   output logic [15:0] resp_rdata_out,
   output logic        resp_err_out,
   output logic        mdc_out,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i,
   output logic        busy_out,
   output logic [1:0]  state_dbg_out
);

   localparam int PH_W = $clog2(2 * MDC_HALF);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * MDC_HALF - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(MDC_HALF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [PH_W-1:0]   ph_q;
   logic [5:0]        bit_q;
   logic [63:0]       frame_q;
   logic              write_q, port_q, last_q;
   logic              mdc_q, mdio_o_q, mdio_oe_q;
   logic              resp_valid_q, resp_port_q, resp_err_q;
   logic [15:0]       resp_rdata_q;
   logic [14:0]       rx_q;
   logic              rx_err_q;
   logic              sync1_q, sync2_q;

   logic              grant_d, accept_d, wr_d, ph_wrap_d;
   logic [4:0]        phy_d, reg_d;
   logic [15:0]       wdata_d;
   logic [63:0]       frame_d;
   logic [PH_W-1:0]   ph_d;
   logic [5:0]        bit_d;

   always_comb begin
      // On a double request the port not granted last wins; last_q resets to 1
      // so port0 wins first after reset.
      grant_d   = (req_valid_in == 2'b11) ? ~last_q : req_valid_in[1];
      accept_d  = (state_q == ST_IDLE) && (|req_valid_in) && !rst_in;
      wr_d      = grant_d ? req_write_in[1]     : req_write_in[0];
      phy_d     = grant_d ? req_phy_in[9:5]     : req_phy_in[4:0];
      reg_d     = grant_d ? req_reg_in[9:5]     : req_reg_in[4:0];
      wdata_d   = grant_d ? req_wdata_in[31:16] : req_wdata_in[15:0];
      // Reads carry 1s in TA/data; those bits are never driven (oe low).
      frame_d   = {32'hFFFF_FFFF, 2'b01, (wr_d ? 2'b01 : 2'b10), phy_d, reg_d,
                   (wr_d ? 2'b10 : 2'b11), (wr_d ? wdata_d : 16'hFFFF)};
      ph_wrap_d = (ph_q == PH_LAST);
      ph_d      = ph_wrap_d ? '0 : ph_q + 1'b1;
      bit_d     = ph_wrap_d ? bit_q + 6'd1 : bit_q;
   end

   assign req_ready_out  = accept_d ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
   assign busy_out       = accept_d || (state_q != ST_IDLE);
   assign resp_valid_out = resp_valid_q;
   assign resp_port_out  = resp_port_q;
   assign resp_rdata_out = resp_rdata_q;
   assign resp_err_out   = resp_err_q;
   assign mdc_out        = mdc_q;
   assign mdio_o         = mdio_o_q;
   assign mdio_oe        = mdio_oe_q;
   assign state_dbg_out  = state_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         ph_q         <= '0;
         bit_q        <= '0;
         frame_q      <= '0;
         write_q      <= 1'b0;
         port_q       <= 1'b0;
         last_q       <= 1'b1;
         mdc_q        <= 1'b0;
         mdio_o_q     <= 1'b1;
         mdio_oe_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_port_q  <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         rx_q         <= '0;
         rx_err_q     <= 1'b0;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
      end else begin
         sync1_q <= mdio_i;
         sync2_q <= sync1_q;
         case (state_q)
            ST_IDLE: begin
               resp_valid_q <= 1'b0;
               if (accept_d) begin
                  state_q   <= ST_SHIFT;
                  port_q    <= grant_d;
                  last_q    <= grant_d;
                  write_q   <= wr_d;
                  frame_q   <= frame_d;
                  ph_q      <= '0;
                  bit_q     <= '0;
                  rx_q      <= '0;
                  rx_err_q  <= 1'b0;
                  mdc_q     <= 1'b0;
                  mdio_o_q  <= 1'b1;   // first preamble bit
                  mdio_oe_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               // Read sampling on the last high cycle of bits 47..62; bit 63 is
               // folded straight into the response below.
               if (!write_q && ph_wrap_d && (bit_q >= 6'd47)) begin
                  if (bit_q == 6'd47) rx_err_q <= sync2_q;
                  else                rx_q     <= {rx_q[13:0], sync2_q};
               end
               if (ph_wrap_d && (bit_q == 6'd63)) begin
                  state_q      <= ST_DONE;
                  mdc_q        <= 1'b0;
                  mdio_oe_q    <= 1'b0;
                  mdio_o_q     <= 1'b1;
                  resp_valid_q <= 1'b1;
                  resp_port_q  <= port_q;
                  resp_rdata_q <= write_q ? 16'h0000 : {rx_q, sync2_q};
                  resp_err_q   <= write_q ? 1'b0 : rx_err_q;
               end else begin
                  ph_q  <= ph_d;
                  bit_q <= bit_d;
                  mdc_q <= (ph_d >= PH_HALF);
                  // Data and enable only move on the first low cycle of a bit.
                  if (ph_d == '0) begin
                     mdio_o_q  <= frame_q[6'd63 - bit_d];
                     mdio_oe_q <= write_q || (bit_d < 6'd46);
                  end
               end
            end
            ST_DONE: begin
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_arbiter_master.sv
module tb_mdio_arbiter_master;

   localparam int H     = 20;
   localparam int FRAME = 128 * H;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [1:0]  req_valid_in;
   logic [1:0]  req_write_in;
   logic [9:0]  req_phy_in;
   logic [9:0]  req_reg_in;
   logic [31:0] req_wdata_in;
   logic [1:0]  req_ready_out;
   logic        resp_valid_out;
   logic        resp_port_out;
   logic [15:0] resp_rdata_out;
   logic        resp_err_out;
   logic        mdc_out;
   logic        mdio_o;
   logic        mdio_oe;
   logic        mdio_i;
   logic        busy_out;
   logic [1:0]  state_dbg_out;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   mdio_arbiter_master #(.MDC_HALF(H)) dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .req_valid_in   (req_valid_in),
      .req_write_in   (req_write_in),
      .req_phy_in     (req_phy_in),
      .req_reg_in     (req_reg_in),
      .req_wdata_in   (req_wdata_in),
      .req_ready_out  (req_ready_out),
      .resp_valid_out (resp_valid_out),
      .resp_port_out  (resp_port_out),
      .resp_rdata_out (resp_rdata_out),
      .resp_err_out   (resp_err_out),
      .mdc_out        (mdc_out),
      .mdio_o         (mdio_o),
      .mdio_oe        (mdio_oe),
      .mdio_i         (mdio_i),
      .busy_out       (busy_out),
      .state_dbg_out  (state_dbg_out)
   );

   // driver tasks
   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst_in = 1'b1;
      repeat (cycles) @(negedge clk);
      rst_in = 1'b0;
   endtask

   task automatic wait_accept(input logic [1:0] exp_ready, input string tag);
      int i;
      for (i = 0; i < 3000; i++) begin
         #1;
         if (req_ready_out !== 2'b00) break;
         @(negedge clk);
      end
      n_vec++;
      if (req_ready_out !== exp_ready) begin
         $display("FAIL %s accept: req_ready_out=%b expected %b after %0d cycles", tag, req_ready_out, exp_ready, i);
         n_err++;
      end
   endtask

   // Walks one frame cycle by cycle from the accept cycle, acting as PHY for reads.
   task automatic check_frame(input logic exp_port, input logic wr, input logic [4:0] phy,
                              input logic [4:0] rg, input logic [15:0] wdata,
                              input logic b47, input logic [15:0] phy_data,
                              input logic exp_err, input logic [1:0] drop, input string tag);
      logic [63:0] frame;
      logic [15:0] exp_rdata;
      int b, ph;
      frame = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, wdata};
      exp_rdata = exp_q.pop_front();
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         if (k == 1) req_valid_in = req_valid_in & ~drop;
         b  = (k - 1) / (2 * H);
         ph = (k - 1) % (2 * H);
         if (!wr && ph == 0 && b >= 46)
            mdio_i = (b == 46) ? 1'b1 : (b == 47) ? b47 : phy_data[63 - b];
         #1;
         n_vec++;
         if (mdc_out !== (ph >= H)) begin
            $display("FAIL %s mdc bit %0d ph %0d: got %b expected %b", tag, b, ph, mdc_out, (ph >= H)); n_err++;
         end
         n_vec++;
         if (mdio_oe !== (wr || b < 46)) begin
            $display("FAIL %s oe bit %0d ph %0d: got %b expected %b", tag, b, ph, mdio_oe, (wr || b < 46)); n_err++;
         end
         if (wr || b < 46) begin
            n_vec++;
            if (mdio_o !== frame[63 - b]) begin
               $display("FAIL %s mdio_o bit %0d ph %0d: got %b expected %b", tag, b, ph, mdio_o, frame[63 - b]); n_err++;
            end
         end
         n_vec++;
         if (resp_valid_out !== 1'b0 || req_ready_out !== 2'b00 || busy_out !== 1'b1) begin
            $display("FAIL %s ctrl k=%0d: valid=%b ready=%b busy=%b expected 0/00/1", tag, k, resp_valid_out, req_ready_out, busy_out); n_err++;
         end
      end
      @(negedge clk);
      mdio_i = 1'b1;
      #1;
      n_vec++;
      if (resp_valid_out !== 1'b1) begin
         $display("FAIL %s latency: resp_valid_out=%b expected 1 at T+%0d", tag, resp_valid_out, FRAME + 1); n_err++;
      end
      n_vec++;
      if (resp_port_out !== exp_port || resp_rdata_out !== exp_rdata || resp_err_out !== exp_err) begin
         $display("FAIL %s resp: port=%b rdata=%h err=%b expected %b/%h/%b", tag, resp_port_out, resp_rdata_out, resp_err_out, exp_port, exp_rdata, exp_err); n_err++;
      end
      n_vec++;
      if (mdc_out !== 1'b0 || mdio_oe !== 1'b0) begin
         $display("FAIL %s done pins: mdc=%b oe=%b expected 0/0", tag, mdc_out, mdio_oe); n_err++;
      end
   endtask

   task automatic check_hold(input logic exp_port, input logic [15:0] exp_rdata, input logic exp_err, input string tag);
      repeat (3) begin
         @(negedge clk);
         #1;
         n_vec++;
         if (resp_valid_out !== 1'b0 || busy_out !== 1'b0 || resp_port_out !== exp_port ||
             resp_rdata_out !== exp_rdata || resp_err_out !== exp_err) begin
            $display("FAIL %s hold: valid=%b busy=%b port=%b rdata=%h err=%b expected 0/0/%b/%h/%b",
                     tag, resp_valid_out, busy_out, resp_port_out, resp_rdata_out, resp_err_out, exp_port, exp_rdata, exp_err);
            n_err++;
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      apply_reset(4);
      #1;
      n_vec++;
      if (mdc_out !== 1'b0 || mdio_o !== 1'b1 || mdio_oe !== 1'b0) begin
         $display("FAIL reset pins: mdc=%b mdio_o=%b oe=%b expected 0/1/0", mdc_out, mdio_o, mdio_oe); n_err++;
      end
      n_vec++;
      if (req_ready_out !== 2'b00 || resp_valid_out !== 1'b0 || busy_out !== 1'b0) begin
         $display("FAIL reset ctrl: ready=%b valid=%b busy=%b expected 00/0/0", req_ready_out, resp_valid_out, busy_out); n_err++;
      end
      n_vec++;
      if (resp_port_out !== 1'b0 || resp_rdata_out !== 16'h0000 || resp_err_out !== 1'b0) begin
         $display("FAIL reset resp: port=%b rdata=%h err=%b expected 0/0000/0", resp_port_out, resp_rdata_out, resp_err_out); n_err++;
      end
      n_vec++;
      if (state_dbg_out !== 2'd0) begin
         $display("FAIL reset state: got %0d expected 0", state_dbg_out); n_err++;
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      req_write_in = 2'b01; req_phy_in = {5'h1A, 5'h01}; req_reg_in = {5'h15, 5'h00};
      req_wdata_in = {16'hBEEF, 16'h2100}; req_valid_in = 2'b01;
      exp_q.push_back(16'h0000);
      wait_accept(2'b01, "write");
      check_frame(1'b0, 1'b1, 5'h01, 5'h00, 16'h2100, 1'b1, 16'hFFFF, 1'b0, 2'b01, "write");
      check_hold(1'b0, 16'h0000, 1'b0, "write");
   endtask

   task automatic test_read();
      @(negedge clk);
      req_write_in = 2'b01; req_phy_in = {5'h0F, 5'h11}; req_reg_in = {5'h02, 5'h1C};
      req_wdata_in = {16'h5555, 16'hAAAA}; req_valid_in = 2'b10;
      exp_q.push_back(16'h0022);
      wait_accept(2'b10, "read");
      check_frame(1'b1, 1'b0, 5'h0F, 5'h02, 16'h0000, 1'b0, 16'h0022, 1'b0, 2'b10, "read");
      check_hold(1'b1, 16'h0022, 1'b0, "read");
   endtask

   task automatic test_read_error();
      @(negedge clk);
      mdio_i = 1'b1;
      req_write_in = 2'b00; req_phy_in = {5'h00, 5'h05}; req_reg_in = {5'h00, 5'h01};
      req_valid_in = 2'b01;
      exp_q.push_back(16'hFFFF);
      wait_accept(2'b01, "rd_err");
      check_frame(1'b0, 1'b0, 5'h05, 5'h01, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 2'b01, "rd_err");
      check_hold(1'b0, 16'hFFFF, 1'b1, "rd_err");
   endtask

   task automatic test_round_robin();
      apply_reset(2);
      req_write_in = 2'b01; req_phy_in = {5'h07, 5'h03}; req_reg_in = {5'h09, 5'h04};
      req_wdata_in = {16'h0000, 16'hA5A5}; req_valid_in = 2'b11;
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h0000);
      wait_accept(2'b01, "rr1");
      check_frame(1'b0, 1'b1, 5'h03, 5'h04, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 2'b00, "rr1");
      wait_accept(2'b10, "rr2");
      check_frame(1'b1, 1'b0, 5'h07, 5'h09, 16'h0000, 1'b0, 16'h1234, 1'b0, 2'b00, "rr2");
      wait_accept(2'b01, "rr3");
      check_frame(1'b0, 1'b1, 5'h03, 5'h04, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 2'b11, "rr3");
      check_hold(1'b0, 16'h0000, 1'b0, "rr3");
   endtask

   task automatic test_reset_mid_frame();
      int seen;
      @(negedge clk);
      req_write_in = 2'b10; req_phy_in = {5'h1F, 5'h00}; req_reg_in = {5'h1F, 5'h00};
      req_wdata_in = {16'h0F0F, 16'h0000}; req_valid_in = 2'b10;
      wait_accept(2'b10, "abort");
      // advance to a few cycles into bit 40
      for (int k = 1; k <= 40 * 2 * H + 4; k++) begin
         @(negedge clk);
         if (k == 1) req_valid_in = 2'b00;
      end
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      #1;
      n_vec++;
      if (mdc_out !== 1'b0 || mdio_oe !== 1'b0 || mdio_o !== 1'b1 || busy_out !== 1'b0 || resp_valid_out !== 1'b0) begin
         $display("FAIL abort pins: mdc=%b oe=%b mdio_o=%b busy=%b valid=%b expected 0/0/1/0/0",
                  mdc_out, mdio_oe, mdio_o, busy_out, resp_valid_out); n_err++;
      end
      seen = 0;
      for (int k = 0; k < FRAME + 20; k++) begin
         @(negedge clk);
         if (resp_valid_out !== 1'b0) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         $display("FAIL abort no_resp: resp_valid_out seen %0d times expected 0", seen); n_err++;
      end
      req_write_in = 2'b01; req_phy_in = {5'h00, 5'h12}; req_reg_in = {5'h00, 5'h0B};
      req_wdata_in = {16'h0000, 16'h8001}; req_valid_in = 2'b01;
      exp_q.push_back(16'h0000);
      wait_accept(2'b01, "after_abort");
      check_frame(1'b0, 1'b1, 5'h12, 5'h0B, 16'h8001, 1'b0, 16'h0000, 1'b0, 2'b01, "after_abort");
   endtask

   initial begin
      rst_in       = 1'b1;
      req_valid_in = 2'b00;
      req_write_in = 2'b00;
      req_phy_in   = '0;
      req_reg_in   = '0;
      req_wdata_in = '0;
      mdio_i       = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_read_error();
      test_round_robin();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
